// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Package : ps2_pkg
// Brief   : Shared PS/2 definitions: FSM state encoding, frame length,
//           command/response byte values and the odd-parity helper.
// Rev     : 1.0  initial release
// ============================================================================
package ps2_pkg;

    localparam int PS2_FRAME_LEN = 11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_INHIBIT   = 3'd1;
    localparam state_t ST_RTS       = 3'd2;
    localparam state_t ST_XFER      = 3'd3;
    localparam state_t ST_WAIT_IDLE = 3'd4;
    localparam state_t ST_RSP       = 3'd5;
    localparam state_t ST_DONE      = 3'd6;
    localparam state_t ST_FAIL      = 3'd7;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module : ps2_line_sync
// Brief  : Two-flop synchronizers for PS2_CLK/PS2_DAT plus a falling-edge
//          strobe on the synchronized clock.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_clk_raw,
    input  logic i_dat_raw,
    output logic o_clk_sync,
    output logic o_dat_sync,
    output logic o_clk_fe
);

    logic [1:0] r_clk_meta;
    logic [1:0] r_dat_meta;
    logic       r_clk_prev;

    // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_meta <= 2'b11;
            r_dat_meta <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_meta <= {r_clk_meta[0], i_clk_raw};
            r_dat_meta <= {r_dat_meta[0], i_dat_raw};
            r_clk_prev <= r_clk_meta[1];
        end
    end

    assign o_clk_sync = r_clk_meta[1];
    assign o_dat_sync = r_dat_meta[1];
    assign o_clk_fe   = r_clk_prev & ~r_clk_meta[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module : ps2_host_tx
// Brief  : Host-to-device PS/2 transmitter with open-drain pin control and
//          device-ack check. Define PS2_TX_RESPONSE_EN to also receive the
//          device's response frame before signalling done.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic [7:0] rsp_data,
    output logic       rsp_valid
);

    localparam int MAX_A   = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] c_inhibit_last = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_rts_last     = CNT_W'(RTS_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);
    localparam logic [3:0]       c_last_bit     = 4'(PS2_FRAME_LEN - 1);

    logic w_clk_sync;
    logic w_dat_sync;
    logic w_clk_fe;
    logic w_timeout;

    state_t           r_state;
    logic [10:0]      r_shift;
    logic [3:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cmd_ready;
    logic             r_done;
    logic             r_error;
    logic             r_clk_oe;
    logic             r_dat_oe;

    ps2_line_sync u_sync (
        .clk        (clock),
        .rst        (reset),
        .i_clk_raw  (ps2_clk_in),
        .i_dat_raw  (ps2_dat_in),
        .o_clk_sync (w_clk_sync),
        .o_dat_sync (w_dat_sync),
        .o_clk_fe   (w_clk_fe)
    );

    assign w_timeout = (r_cnt == c_timeout_last);

`ifdef PS2_TX_RESPONSE_EN
    logic [7:0]  r_rsp_data;
    logic        r_rsp_valid;
    logic [10:0] w_rx_frame;
    logic        w_rx_ok;

    // Frame as it will look once the current bit is shifted in; bit 0 = start.
    assign w_rx_frame = {w_dat_sync, r_shift[10:1]};
    assign w_rx_ok    = ~w_rx_frame[0] & w_rx_frame[10] & (^w_rx_frame[9:1]);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_clk_oe    <= 1'b0;
            r_dat_oe    <= 1'b0;
`ifdef PS2_TX_RESPONSE_EN
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
`ifdef PS2_TX_RESPONSE_EN
            r_rsp_valid <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_shift     <= {1'b1, odd_parity(cmd_data), cmd_data, 1'b0};
                        r_cnt       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_clk_oe    <= 1'b1;
                        r_state     <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (r_cnt == c_inhibit_last) begin
                        r_cnt    <= '0;
                        r_dat_oe <= ~r_shift[0];
                        r_state  <= ST_RTS;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                ST_RTS: begin
                    if (r_cnt == c_rts_last) begin
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        r_clk_oe  <= 1'b0;
                        r_state   <= ST_XFER;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                // r_shift[1] is always the next bit to present on the line.
                ST_XFER: begin
                    if (w_clk_fe) begin
                        r_cnt <= '0;
                        if (r_bit_cnt == c_last_bit) begin
                            if (!w_dat_sync) begin
                                r_state <= ST_WAIT_IDLE;
                            end else begin
                                r_error  <= 1'b1;
                                r_clk_oe <= 1'b0;
                                r_dat_oe <= 1'b0;
                                r_state  <= ST_FAIL;
                            end
                        end else begin
                            r_shift   <= {1'b1, r_shift[10:1]};
                            r_dat_oe  <= ~r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else if (w_timeout) begin
                        r_error  <= 1'b1;
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_state  <= ST_FAIL;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                ST_WAIT_IDLE: begin
                    if (w_clk_sync && w_dat_sync) begin
`ifdef PS2_TX_RESPONSE_EN
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= ST_RSP;
`else
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
`endif
                    end else if (w_clk_fe) begin
                        r_cnt <= '0;
                    end else if (w_timeout) begin
                        r_error  <= 1'b1;
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_state  <= ST_FAIL;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

`ifdef PS2_TX_RESPONSE_EN
                ST_RSP: begin
                    if (w_clk_fe) begin
                        r_cnt   <= '0;
                        r_shift <= w_rx_frame;
                        if (r_bit_cnt == c_last_bit) begin
                            if (w_rx_ok) begin
                                r_rsp_data  <= w_rx_frame[8:1];
                                r_rsp_valid <= 1'b1;
                                r_done      <= 1'b1;
                                r_state     <= ST_DONE;
                            end else begin
                                r_error <= 1'b1;
                                r_state <= ST_FAIL;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_state <= ST_FAIL;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
`endif

                ST_DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                ST_FAIL: begin
                    r_clk_oe    <= 1'b0;
                    r_dat_oe    <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_clk_oe    <= 1'b0;
                    r_dat_oe    <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign done       = r_done;
    assign error      = r_error;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;

`ifdef PS2_TX_RESPONSE_EN
    assign rsp_data  = r_rsp_data;
    assign rsp_valid = r_rsp_valid;
`else
    assign rsp_data  = 8'h00;
    assign rsp_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_ps2_host_tx
// Brief  : Directed bench for ps2_host_tx with a 40-cycle PS/2 device model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ps2_host_tx;
    import ps2_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, done, error;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic [7:0] rsp_data;
    logic       rsp_valid;

    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int rsp_cnt = 0;
    logic prev_term = 1'b0;

    logic [9:0] bits;
    int hi, lat, k, d0, e0, r0;

    always #5 clock = ~clock;

    ps2_host_tx #(
        .INHIBIT_CYCLES (20),
        .RTS_CYCLES     (4),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .done       (done),
        .error      (error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .rsp_data   (rsp_data),
        .rsp_valid  (rsp_valid)
    );

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse bookkeeping plus the handshake rules around every done/error.
    always @(negedge clock) begin
        if (prev_term) check("ready_after_term", 32'(cmd_ready), 32'd1);
        if (done || error) check("ready_during_term", 32'(cmd_ready), 32'd0);
        if (error) check("oe_released_on_error", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (rsp_valid) rsp_cnt++;
        prev_term = done | error;
    end

    task automatic start_cmd(input logic [7:0] b);
        cmd_data  = b;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_release(output int h);
        h = 0;
        while (ps2_clk_oe === 1'b1 && h < 100) begin
            h++;
            tick;
        end
    endtask

    // Device clocks the host frame; samples on rising edges, acks at fall 11.
    task automatic dev_frame(input int nfalls, input logic ack, output logic [9:0] b, output int l);
        b = '0;
        l = 0;
        repeat (5) tick;
        for (int i = 1; i <= nfalls; i++) begin
            dev_clk = 1'b0;
            for (int j = 1; j <= 20; j++) begin
                tick;
                if (i == 1 && l == 0 && ps2_dat_oe === 1'b0) l = j;
            end
            if (i == nfalls && nfalls < 11) break;
            dev_clk = 1'b1;
            if (i <= 10) b[i-1] = ps2_dat_in;
            if (i == 10 && ack) dev_dat = 1'b0;
            if (i == 11) dev_dat = 1'b1;
            repeat (20) tick;
        end
    endtask

    task automatic dev_reply(input logic [7:0] b);
        logic [10:0] f;
        f = {1'b1, ~^b, b, 1'b0};
        repeat (20) tick;
        for (int i = 0; i < 11; i++) begin
            dev_dat = f[i];
            repeat (5) tick;
            dev_clk = 1'b0;
            repeat (20) tick;
            dev_clk = 1'b1;
            repeat (15) tick;
        end
        dev_dat = 1'b1;
    endtask

    task automatic run_cmd(input logic [7:0] b, input logic ack, input int nfalls,
                           output logic [9:0] fb, output int l);
        int h;
        start_cmd(b);
        check("accept_to_clk_oe", 32'(ps2_clk_oe), 32'd1);
        wait_release(h);
        check("clk_oe_high_cycles", h, 32'd24);
        check("start_bit_held", 32'(ps2_dat_oe), 32'd1);
        dev_frame(nfalls, ack, fb, l);
        if (ack && nfalls == 11) dev_reply(PS2_RSP_ACK);
        repeat (10) tick;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        repeat (3) tick;

        // Set LEDs: LSB-first 1,0,1,1,0,1,1,1, parity 1, stop 1
        d0 = done_cnt; e0 = err_cnt; r0 = rsp_cnt;
        run_cmd(PS2_CMD_SET_LEDS, 1'b1, 11, bits, lat);
        check("frame_ED", 32'(bits), 32'h3ED);
        check("dat_oe_latency", lat, 32'd3);
        check("done_ED", done_cnt - d0, 32'd1);
        check("err_ED", err_cnt - e0, 32'd0);
`ifdef PS2_TX_RESPONSE_EN
        check("rsp_data_FA", 32'(rsp_data), 32'hFA);
        check("rsp_valid_once", rsp_cnt - r0, 32'd1);
`else
        check("rsp_data_tied", 32'(rsp_data), 32'd0);
        check("rsp_valid_tied", rsp_cnt - r0, 32'd0);
`endif

        d0 = done_cnt;
        run_cmd(8'h00, 1'b1, 11, bits, lat);
        check("frame_00", 32'(bits), 32'h300);
        check("done_00", done_cnt - d0, 32'd1);

        // Enable scanning with a competing request while busy
        d0 = done_cnt;
        fork
            run_cmd(PS2_CMD_ENABLE, 1'b1, 11, bits, lat);
            begin
                repeat (100) tick;
                cmd_data  = 8'h55;
                cmd_valid = 1'b1;
                repeat (100) tick;
                check("ready_low_busy", 32'(cmd_ready), 32'd0);
                repeat (100) tick;
                cmd_valid = 1'b0;
            end
        join
        check("frame_F4", 32'(bits), 32'h2F4);
        check("done_F4", done_cnt - d0, 32'd1);
        repeat (50) tick;
        check("no_requeue_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("no_requeue_ready", 32'(cmd_ready), 32'd1);

        // Device leaves data high at fall 11
        d0 = done_cnt; e0 = err_cnt;
        run_cmd(PS2_CMD_RESET, 1'b0, 11, bits, lat);
        check("frame_FF_nack", 32'(bits), 32'h3FF);
        check("nack_error", err_cnt - e0, 32'd1);
        check("nack_no_done", done_cnt - d0, 32'd0);

        // Device never clocks
        e0 = err_cnt;
        start_cmd(PS2_CMD_ENABLE);
        wait_release(hi);
        k = 0;
        while (error !== 1'b1 && k < 400) begin
            tick;
            k++;
        end
        check("timeout_cycles", k, 32'd200);
        repeat (5) tick;
        check("timeout_error", err_cnt - e0, 32'd1);
        check("timeout_ready", 32'(cmd_ready), 32'd1);

        // Reset while bit 3 (zero) is driven after fall 4
        run_cmd(8'h00, 1'b1, 4, bits, lat);
        check("bit3_driven", 32'(ps2_dat_oe), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("async_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("async_rst_ready", 32'(cmd_ready), 32'd1);
        tick;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        repeat (3) tick;

        // Reset during the inhibit phase
        start_cmd(PS2_CMD_SET_LEDS);
        repeat (5) tick;
        check("inhibit_clk_oe", 32'(ps2_clk_oe), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_inhibit", 32'(ps2_clk_oe), 32'd0);
        tick;
        repeat (3) tick;
        reset = 1'b0;
        repeat (3) tick;

        d0 = done_cnt; e0 = err_cnt;
        run_cmd(PS2_CMD_RESET, 1'b1, 11, bits, lat);
        check("frame_FF_recover", 32'(bits), 32'h3FF);
        check("done_recover", done_cnt - d0, 32'd1);
        check("err_recover", err_cnt - e0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
